counter_watermark_monitor: RTL

//  Downstream observer of the up/down counter. Snoops the counter's value, value_next and

---
 rtl/counter_watermark_monitor.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/counter_watermark_monitor.sv
`default_nettype none
// ============================================================================
// Module   : counter_watermark_monitor
// Purpose  : Observes an up/down counter. It sorts the counter value into
//            NORMAL, HIGH or LOW. A state change needs the exit condition to
//            hold for DWELL cycles in a row, and the exit thresholds carry
//            hysteresis. It also keeps sticky flags for watermark entry,
//            wrap-around and value_next inconsistency.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            enable            - 0 freezes state and blocks flag sets
//            value, value_next - counter current / next value (snooped)
//            reinit            - counter reinit strobe, masks the checks
//            incr_valid, incr  - counter increment request (snooped)
//            decr_valid, decr  - counter decrement request (snooped)
//            low_mark, high_mark - watermarks
//            irq_clear         - clears all sticky flags
//            state             - 0=NORMAL, 1=HIGH, 2=LOW
//            irq_high, irq_low, ovf_flag, udf_flag, mismatch_flag - sticky
//            irq               - OR of the sticky flags
// Revision : 1.0 - initial release
// ============================================================================
module counter_watermark_monitor #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STEP_W = 2,
  parameter int unsigned DWELL  = 3,
  parameter int unsigned HYST   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [WIDTH-1:0]  value,
  input  logic [WIDTH-1:0]  value_next,
  input  logic              reinit,
  input  logic              incr_valid,
  input  logic [STEP_W-1:0] incr,
  input  logic              decr_valid,
  input  logic [STEP_W-1:0] decr,
  input  logic [WIDTH-1:0]  low_mark,
  input  logic [WIDTH-1:0]  high_mark,
  input  logic              irq_clear,
  output logic [1:0]        state,
  output logic              irq_high,
  output logic              irq_low,
  output logic              ovf_flag,
  output logic              udf_flag,
  output logic              mismatch_flag,
  output logic              irq
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_HIGH   = 2'd1,
    ST_LOW    = 2'd2
  } state_e;

  localparam int unsigned      c_DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [c_DW-1:0]  c_DWELL_LAST = c_DW'(DWELL - 1);
  localparam logic [WIDTH-1:0] c_HYST       = WIDTH'(HYST);
  localparam logic [WIDTH-1:0] c_MAX        = '1;

  state_e            state_q, state_d;
  logic [c_DW-1:0]   dwell_q, dwell_d;
  logic              irq_high_q, irq_high_d;
  logic              irq_low_q, irq_low_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              mism_q, mism_d;

  logic [WIDTH-1:0]  w_hi_exit_thr;
  logic [WIDTH:0]    w_lo_sum;
  logic [WIDTH-1:0]  w_lo_exit_thr;
  logic [WIDTH+1:0]  w_incr_ext;
  logic [WIDTH+1:0]  w_decr_ext;
  logic [WIDTH+1:0]  w_sum;
  logic              w_check;
  logic              w_ovf_set;
  logic              w_udf_set;
  logic              w_mism_set;
  logic              w_exit;
  state_e            w_target;
  logic              w_enter_high;
  logic              w_enter_low;

  // Exit thresholds with hysteresis. They saturate at the ends of the value range.
  always_comb begin
    w_hi_exit_thr = (high_mark >= c_HYST) ? (high_mark - c_HYST) : '0;
    w_lo_sum      = {1'b0, low_mark} + {1'b0, c_HYST};
    w_lo_exit_thr = w_lo_sum[WIDTH] ? c_MAX : w_lo_sum[WIDTH-1:0];
  end

  // Expected next value, computed two bits wider than WIDTH. The top bit is the
  // sign (underflow). With a clear sign, bit WIDTH set means the sum passed the
  // maximum value (overflow).
  always_comb begin
    w_incr_ext = incr_valid ? {{(WIDTH+2-STEP_W){1'b0}}, incr} : '0;
    w_decr_ext = decr_valid ? {{(WIDTH+2-STEP_W){1'b0}}, decr} : '0;
    w_sum      = {2'b00, value} + w_incr_ext - w_decr_ext;
    w_check    = enable & ~reinit;
    w_udf_set  = w_check & w_sum[WIDTH+1];
    w_ovf_set  = w_check & ~w_sum[WIDTH+1] & w_sum[WIDTH];
    w_mism_set = w_check & (value_next != w_sum[WIDTH-1:0]);
  end

  // Classification and dwell filtering
  always_comb begin
    state_d      = state_q;
    dwell_d      = '0;
    w_exit       = 1'b0;
    w_target     = ST_NORMAL;
    w_enter_high = 1'b0;
    w_enter_low  = 1'b0;

    case (state_q)
      ST_NORMAL: begin
        // HIGH has priority when both watermarks are met. This happens when
        // low_mark >= high_mark.
        if (value >= high_mark) begin
          w_exit   = 1'b1;
          w_target = ST_HIGH;
        end else if (value <= low_mark) begin
          w_exit   = 1'b1;
          w_target = ST_LOW;
        end
      end
      ST_HIGH: w_exit = (value <= w_hi_exit_thr);
      ST_LOW:  w_exit = (value >= w_lo_exit_thr);
      default: w_exit = 1'b0;
    endcase

    if (enable) begin
      if (w_exit) begin
        if (dwell_q == c_DWELL_LAST) begin
          state_d      = w_target;
          w_enter_high = (w_target == ST_HIGH);
          w_enter_low  = (w_target == ST_LOW);
        end else begin
          dwell_d = dwell_q + c_DW'(1);
        end
      end
      // The encoding 2'b11 is never produced. If it ever appears, return to NORMAL.
      if (state_q != ST_NORMAL && state_q != ST_HIGH && state_q != ST_LOW) begin
        state_d = ST_NORMAL;
      end
    end
  end

  // Sticky flags. A set on the same edge as irq_clear wins over the clear.
  always_comb begin
    irq_high_d = (irq_high_q & ~irq_clear) | w_enter_high;
    irq_low_d  = (irq_low_q  & ~irq_clear) | w_enter_low;
    ovf_d      = (ovf_q      & ~irq_clear) | w_ovf_set;
    udf_d      = (udf_q      & ~irq_clear) | w_udf_set;
    mism_d     = (mism_q     & ~irq_clear) | w_mism_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_NORMAL;
      dwell_q    <= '0;
      irq_high_q <= 1'b0;
      irq_low_q  <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      mism_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      irq_high_q <= irq_high_d;
      irq_low_q  <= irq_low_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      mism_q     <= mism_d;
    end
  end

  assign state         = state_q;
  assign irq_high      = irq_high_q;
  assign irq_low       = irq_low_q;
  assign ovf_flag      = ovf_q;
  assign udf_flag      = udf_q;
  assign mismatch_flag = mism_q;
  assign irq           = irq_high_q | irq_low_q | ovf_q | udf_q | mism_q;

endmodule
`default_nettype wire
